t4_affine_pipe: RTL and testbench

- Pipelined, parametrised successor to the combinational tap-4 MCM for affine 1/16-precision interpolation.
- Each accepted beat carries LANES signed samples and one 4-bit fractional phase.
- The block multiplies every lane by the tap-4 coefficient for that phase, using the shared shift-add terms 1, 4 and 8.
- Sits between the reference-sample fetch and the tap-sum adder tree, with valid/ready flow control on both sides.

---
 rtl/t4_affine_pipe.sv | 118 +++++++++++
 tb/tb_t4_affine_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/t4_affine_pipe.sv
// t4_affine_pipe: two-stage pipelined tap-4 multiplier for 1/16-phase affine
// interpolation. Each beat carries LANES signed samples sharing one phase; every
// lane is scaled by the tap-4 coefficient for that phase using only shift-add
// terms built from x, 4x and 8x. Valid/ready on both sides, capacity 2 beats.
module t4_affine_pipe #(
    parameter int IN_W  = 11,
    parameter int LANES = 4,
    parameter int OUT_W = IN_W + 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_frac,
    input  logic [LANES*IN_W-1:0]    in_x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   out_y,
    output logic [3:0]               out_frac
);

    logic                    s1_en;
    logic                    s2_en;
    logic                    vld_p1;
    logic                    vld_p2;
    logic [3:0]              frac_p1;
    logic signed [OUT_W-1:0] x_ext [LANES];
    logic signed [OUT_W-1:0] w1_p1 [LANES];
    logic signed [OUT_W-1:0] w4_p1 [LANES];
    logic signed [OUT_W-1:0] w8_p1 [LANES];

    // Magnitude of the tap-4 coefficient times x, built from the shared x, 4x, 8x
    // terms. The coefficient is never positive, so the caller negates the result.
    function automatic logic signed [OUT_W-1:0] tap4_mag(
        input logic [3:0]              frac,
        input logic signed [OUT_W-1:0] w1,
        input logic signed [OUT_W-1:0] w4,
        input logic signed [OUT_W-1:0] w8
    );
        logic signed [OUT_W-1:0] w2, w3, w5, w9, w10, w11, m;
        w2  = w1 <<< 1;
        w3  = w4 - w1;
        w5  = w4 + w1;
        w9  = w8 + w1;
        w10 = w5 <<< 1;
        w11 = w8 + w4 - w1;
        case (frac)
            4'd0:    m = '0;
            4'd1:    m = w2;
            4'd2:    m = w3;
            4'd3:    m = w4;
            4'd4:    m = w5;
            4'd5:    m = w8;
            4'd6:    m = w10;
            4'd7:    m = w10;
            4'd8:    m = w11;
            4'd9:    m = w11;
            4'd10:   m = w9;
            4'd11:   m = w11;
            4'd12:   m = w10;
            4'd13:   m = w8;
            4'd14:   m = w5;
            default: m = w3;
        endcase
        return m;
    endfunction

    // Handshake: a stage advances when it is empty or the stage after it advances.
    assign s2_en     = !vld_p2 || out_ready;
    assign s1_en     = !vld_p1 || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = vld_p2;

    // Sign-extend each input lane to the full product width.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            x_ext[l] = {{(OUT_W-IN_W){in_x[l*IN_W+IN_W-1]}}, in_x[l*IN_W +: IN_W]};
        end
    end

    // ---- stage 1: valid tracking ----
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (s1_en)
            vld_p1 <= in_valid;
    end

    // Stage 1 data: capture x, 4x, 8x and the phase only on an input transfer.
    always_ff @(posedge clk) begin
        if (s1_en && in_valid) begin
            frac_p1 <= in_frac;
            for (int l = 0; l < LANES; l++) begin
                w1_p1[l] <= x_ext[l];
                w4_p1[l] <= x_ext[l] <<< 2;
                w8_p1[l] <= x_ext[l] <<< 3;
            end
        end
    end

    // ---- stage 2: select magnitude by phase, negate, drive outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            out_y    <= '0;
            out_frac <= 4'd0;
        end else if (s2_en) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_frac <= frac_p1;
                for (int l = 0; l < LANES; l++) begin
                    out_y[l*OUT_W +: OUT_W] <= -tap4_mag(frac_p1, w1_p1[l], w4_p1[l], w8_p1[l]);
                end
            end
        end
    end

endmodule

// File: tb/tb_t4_affine_pipe.sv
// Testbench for t4_affine_pipe: directed vectors with hand-computed products,
// backpressure, bubble collapse and reset flush, plus a randomised handshake run
// checked against a multiply-based reference model through a scoreboard.
module tb_t4_affine_pipe;

    localparam int IW = 11;
    localparam int NL = 4;
    localparam int OW = IW + 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_frac;
    logic [NL*IW-1:0]  in_x;
    logic              out_valid;
    logic              out_ready;
    logic [NL*OW-1:0]  out_y;
    logic [3:0]        out_frac;

    int total;
    int bad;
    int n_in;
    int n_out;

    int coef [16] = '{0, -2, -3, -4, -5, -8, -10, -10, -11, -11, -9, -11, -10, -8, -5, -3};
    int sweep [16] = '{0, 2048, 3072, 4096, 5120, 8192, 10240, 10240,
                       11264, 11264, 9216, 11264, 10240, 8192, 5120, 3072};

    logic [63:0] exp_q [$];
    logic [63:0] mon_e;
    logic [NL*OW-1:0] mon_y;
    int mon_xi;
    int mon_p;

    t4_affine_pipe #(.IN_W(IW), .LANES(NL), .OUT_W(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_frac   (in_frac),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_frac  (out_frac)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    function automatic logic [NL*IW-1:0] px(input int a3, input int a2, input int a1, input int a0);
        return {a3[IW-1:0], a2[IW-1:0], a1[IW-1:0], a0[IW-1:0]};
    endfunction

    function automatic logic [NL*OW-1:0] py(input int a3, input int a2, input int a1, input int a0);
        return {a3[OW-1:0], a2[OW-1:0], a1[OW-1:0], a0[OW-1:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: evaluated mid-cycle, so handshake values are those the next edge sees.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("sb_spurious_out", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_y", {4'd0, out_y}, {4'd0, mon_e[NL*OW-1:0]});
                    chk("sb_frac", {60'd0, out_frac}, {60'd0, mon_e[63:60]});
                end
            end
            if (in_valid && in_ready) begin
                n_in++;
                for (int l = 0; l < NL; l++) begin
                    mon_xi = int'($signed(in_x[l*IW +: IW]));
                    mon_p  = mon_xi * coef[in_frac];
                    mon_y[l*OW +: OW] = mon_p[OW-1:0];
                end
                exp_q.push_back({in_frac, mon_y});
            end
        end
    end

    initial begin
        logic [NL*OW-1:0] r1, r2, r3;
        int cyc;
        total     = 0;
        bad       = 0;
        n_in      = 0;
        n_out     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_frac   = 4'd0;
        in_x      = '0;
        out_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_y", {4'd0, out_y}, 64'd0);
        chk("rst_out_frac", {60'd0, out_frac}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Test 1: single beat, latency 2
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_frac   = 4'd8;
        in_x      = px(100, -1, 0, 1023);
        step();
        in_valid = 1'b0;
        chk("t1_lat1_valid", {63'd0, out_valid}, 64'd0);
        step();
        chk("t1_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_y", {4'd0, out_y}, {4'd0, py(-1100, 11, 0, -11253)});
        chk("t1_frac", {60'd0, out_frac}, 64'd8);
        step();
        chk("t1_drain", {63'd0, out_valid}, 64'd0);

        // Test 2: phase sweep with most negative input, one beat per cycle
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                in_valid = 1'b1;
                in_frac  = i[3:0];
                in_x     = px(-1024, -1024, -1024, -1024);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 1) begin
                chk("t2_valid", {63'd0, out_valid}, 64'd1);
                chk("t2_y", {4'd0, out_y},
                    {4'd0, py(sweep[i-1], sweep[i-1], sweep[i-1], sweep[i-1])});
                chk("t2_frac", {60'd0, out_frac}, 64'(i-1));
            end
        end
        step();
        chk("t2_drain", {63'd0, out_valid}, 64'd0);

        // Test 3: backpressure with three back-to-back beats
        r1 = py(-10, 14, -200, 2);
        r2 = py(-15, 21, -300, 3);
        r3 = py(-20, 28, -400, 4);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_x      = px(5, -7, 100, -1);
        in_frac   = 4'd1;
        #1;
        chk("t3_rdy1", {63'd0, in_ready}, 64'd1);
        step();
        in_frac = 4'd2;
        #1;
        chk("t3_rdy2", {63'd0, in_ready}, 64'd1);
        step();
        in_frac = 4'd3;
        #1;
        chk("t3_rdy3_blocked", {63'd0, in_ready}, 64'd0);
        chk("t3_hold_valid", {63'd0, out_valid}, 64'd1);
        chk("t3_hold_y", {4'd0, out_y}, {4'd0, r1});
        step();
        chk("t3_stall_y", {4'd0, out_y}, {4'd0, r1});
        chk("t3_stall_frac", {60'd0, out_frac}, 64'd1);
        chk("t3_stall_rdy", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        #1;
        chk("t3_rdy_release", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        chk("t3_out2_y", {4'd0, out_y}, {4'd0, r2});
        chk("t3_out2_frac", {60'd0, out_frac}, 64'd2);
        step();
        chk("t3_out3_y", {4'd0, out_y}, {4'd0, r3});
        chk("t3_out3_frac", {60'd0, out_frac}, 64'd3);
        step();
        chk("t3_empty", {63'd0, out_valid}, 64'd0);

        // Test 4: bubble collapse while stage 2 is stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_frac   = 4'd5;
        in_x      = px(1, 2, 3, 4);
        step();
        in_valid = 1'b0;
        step();
        chk("t4_s2_full", {63'd0, out_valid}, 64'd1);
        chk("t4_s2_y", {4'd0, out_y}, {4'd0, py(-8, -16, -24, -32)});
        chk("t4_bubble_rdy", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_frac  = 4'd6;
        in_x     = px(-3, 7, 0, 50);
        step();
        in_valid = 1'b0;
        chk("t4_full_rdy", {63'd0, in_ready}, 64'd0);
        chk("t4_hold_frac", {60'd0, out_frac}, 64'd5);

        // Test 5: reset flushes both full stages
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t5_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_rdy", {63'd0, in_ready}, 64'd1);
        chk("t5_y", {4'd0, out_y}, 64'd0);
        chk("t5_frac", {60'd0, out_frac}, 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_no_ghost", {63'd0, out_valid}, 64'd0);
        end

        // Test 6: random handshake against the reference model
        n_in  = 0;
        n_out = 0;
        cyc   = 0;
        while (n_in < 400 && cyc < 5000) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_frac   = 4'($urandom_range(0, 15));
            in_x      = {12'($urandom), $urandom};
            if ($urandom_range(0, 7) == 0)
                in_x = px(-1024, 1023, -1024, 1023);
            step();
            cyc++;
        end
        chk("t6_in_budget", {63'd0, n_in >= 400}, 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            step();
            cyc++;
        end
        step();
        chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t6_count", 64'(n_out), 64'(n_in));
        chk("t6_idle", {63'd0, out_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
